mul_issue_ctrl: RTL



---
 rtl/mul_issue_ctrl_if.sv | 30 +++
 rtl/mul_issue_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/mul_issue_ctrl_if.sv
// Decode <-> multiply issue controller handshake: issue request, hazard stall,
// per-stage enables and the shared register-file write port.
interface mul_issue_ctrl_if #(
    parameter int MUL_STAGES = 5
) ();
    logic                  issue_valid;
    logic                  issue_is_mul;
    logic [4:0]            issue_dst;
    logic [4:0]            issue_src1;
    logic [4:0]            issue_src2;
    logic                  flush;
    logic                  issue_ready;
    logic [MUL_STAGES-1:0] stage_valid;
    logic                  wb_valid;
    logic                  wb_sel;
    logic [4:0]            wb_dst;
    logic                  fwd_src1;
    logic                  fwd_src2;
    logic                  busy;

    modport master (
        output issue_valid, issue_is_mul, issue_dst, issue_src1, issue_src2, flush,
        input  issue_ready, stage_valid, wb_valid, wb_sel, wb_dst, fwd_src1, fwd_src2, busy
    );

    modport slave (
        input  issue_valid, issue_is_mul, issue_dst, issue_src1, issue_src2, flush,
        output issue_ready, stage_valid, wb_valid, wb_sel, wb_dst, fwd_src1, fwd_src2, busy
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Multiply pipeline issue controller: tracks M1..Mn occupancy, stalls decode on
// RAW/WAW/write-port hazards, arbitrates the RF write port. Option: MUL_FWD_EN.
module mul_issue_ctrl #(
    parameter int MUL_STAGES = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_issue_ctrl_if.slave bus
);
    localparam int LAST = MUL_STAGES - 1;
    localparam int PRE  = MUL_STAGES - 2;

    logic [MUL_STAGES-1:0]      vld_q, vld_d;
    logic [MUL_STAGES-1:0][4:0] dst_q, dst_d;
    logic                       alu_wb_v_q, alu_wb_v_d;
    logic [4:0]                 alu_wb_dst_q, alu_wb_dst_d;

    logic raw1_early, raw2_early, raw1_last, raw2_last;
    logic raw_stall, waw, structural, stall, accept;

    // Hazard detection; the last stage is split out so forwarding can waive it.
    always_comb begin
        raw1_early = 1'b0;
        raw2_early = 1'b0;
        waw        = 1'b0;
        for (int k = 0; k < LAST; k++) begin
            if (vld_q[k] && bus.issue_src1 != 5'd0 && dst_q[k] == bus.issue_src1) raw1_early = 1'b1;
            if (vld_q[k] && bus.issue_src2 != 5'd0 && dst_q[k] == bus.issue_src2) raw2_early = 1'b1;
        end
        for (int k = 0; k < MUL_STAGES; k++) begin
            if (vld_q[k] && bus.issue_dst != 5'd0 && dst_q[k] == bus.issue_dst) waw = 1'b1;
        end
        raw1_last = vld_q[LAST] && bus.issue_src1 != 5'd0 && dst_q[LAST] == bus.issue_src1;
        raw2_last = vld_q[LAST] && bus.issue_src2 != 5'd0 && dst_q[LAST] == bus.issue_src2;
`ifdef MUL_FWD_EN
        raw_stall = raw1_early | raw2_early;
`else
        raw_stall = raw1_early | raw2_early | raw1_last | raw2_last;
`endif
        // An ALU op issued now writes next cycle, exactly when M(n-1) reaches Mn.
        structural = vld_q[PRE];
        stall      = raw_stall | (~bus.issue_is_mul & (waw | structural));
        accept     = rst_n & bus.issue_valid & ~bus.flush & ~stall;
    end

    always_comb begin
        vld_d        = {vld_q[MUL_STAGES-2:0], accept & bus.issue_is_mul};
        dst_d        = {dst_q[MUL_STAGES-2:0], (accept & bus.issue_is_mul) ? bus.issue_dst : 5'd0};
        alu_wb_v_d   = accept & ~bus.issue_is_mul;
        alu_wb_dst_d = alu_wb_v_d ? bus.issue_dst : 5'd0;
        if (bus.flush) begin
            vld_d      = '0;
            alu_wb_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q        <= '0;
            dst_q        <= '0;
            alu_wb_v_q   <= 1'b0;
            alu_wb_dst_q <= 5'd0;
        end else begin
            vld_q        <= vld_d;
            dst_q        <= dst_d;
            alu_wb_v_q   <= alu_wb_v_d;
            alu_wb_dst_q <= alu_wb_dst_d;
        end
    end

    // The multiply owns the port whenever it is in Mn; the structural stall
    // guarantees no ALU result is pending in that cycle.
    always_comb begin
        bus.wb_sel = 1'b0;
        bus.wb_dst = 5'd0;
        if (vld_q[LAST]) begin
            bus.wb_sel = 1'b1;
            bus.wb_dst = dst_q[LAST];
        end else if (alu_wb_v_q) begin
            bus.wb_dst = alu_wb_dst_q;
        end
        bus.wb_valid = rst_n && (vld_q[LAST] || alu_wb_v_q) && bus.wb_dst != 5'd0;
    end

    assign bus.issue_ready = accept;
    assign bus.stage_valid = vld_q;
    assign bus.busy        = |vld_q;

`ifdef MUL_FWD_EN
    assign bus.fwd_src1 = rst_n & bus.issue_valid & raw1_last & ~raw1_early;
    assign bus.fwd_src2 = rst_n & bus.issue_valid & raw2_last & ~raw2_early;
`else
    assign bus.fwd_src1 = 1'b0;
    assign bus.fwd_src2 = 1'b0;
`endif
endmodule
